// File: rtl/walking_circle_ctrl.sv
// walking_circle_ctrl: sequencer that produces the one-cycle step strobe for the
// walking-circle animation datapath. It supports run, pause and single-step
// control, programmable speed levels and lap counting.
// Optional feature macro: WC_LAP_LIMIT_EN adds a DONE state that halts the run
// once LAP_LIMIT laps have completed. The LAP_LIMIT parameter exists only in
// that build.
module walking_circle_ctrl #(
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int BASE_DIV        = 12_500_000,
  parameter int NUM_SPEEDS      = 4,
  parameter int DIV_WIDTH       = $clog2(BASE_DIV),
  parameter int LAP_WIDTH       = 8
`ifdef WC_LAP_LIMIT_EN
  ,
  parameter int LAP_LIMIT       = 10
`endif
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          step_i,
  input  logic                          speed_up_i,
  input  logic                          speed_dn_i,
  output logic                          overflow_o,
  output logic                          running_o,
  output logic [$clog2(NUM_SPEEDS)-1:0] speed_o,
  output logic [LAP_WIDTH-1:0]          lap_cnt_o,
  output logic                          done_o
);

  localparam int SPEED_WIDTH = $clog2(NUM_SPEEDS);
  localparam int POS_WIDTH   = $clog2(2 * NUM_OF_DISPLAYS);
  localparam logic [SPEED_WIDTH-1:0] SPEED_MAX = SPEED_WIDTH'(NUM_SPEEDS - 1);
  localparam logic [POS_WIDTH-1:0]   POS_LAST  = POS_WIDTH'(2 * NUM_OF_DISPLAYS - 1);

`ifdef WC_LAP_LIMIT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2} state_t;
`endif

  // Last divider value of a step period at the given speed (period = BASE_DIV >> speed).
  function automatic logic [DIV_WIDTH-1:0] period_last(input logic [SPEED_WIDTH-1:0] spd);
    int period;
    period = BASE_DIV >> spd;
    return DIV_WIDTH'(period - 32'sd1);
  endfunction

  state_t                 state_r;
  state_t                 state_base_s;
  state_t                 state_nxt_s;
  logic [DIV_WIDTH-1:0]   div_cnt_r;
  logic [DIV_WIDTH-1:0]   div_last_s;
  logic [SPEED_WIDTH-1:0] speed_r;
  logic [SPEED_WIDTH-1:0] speed_nxt_s;
  logic                   speed_chg_s;
  logic [POS_WIDTH-1:0]   pos_r;
  logic [LAP_WIDTH-1:0]   lap_cnt_r;
  logic [LAP_WIDTH-1:0]   lap_nxt_s;
  logic                   pos_wrap_s;
  logic                   tick_s;
  logic                   strobe_s;
  logic                   restart_s;

  assign speed_o   = speed_r;
  assign lap_cnt_o = lap_cnt_r;

  // Next-state, speed, strobe and lap decisions for the coming clock edge.
  always_comb begin
    div_last_s   = period_last(speed_r);
    speed_nxt_s  = speed_r;
    speed_chg_s  = 1'b0;
    restart_s    = 1'b0;
    state_base_s = state_r;
    state_nxt_s  = state_r;
    lap_nxt_s    = lap_cnt_r;

    // Opposing speed requests in one cycle cancel; limits saturate.
    if (speed_up_i && !speed_dn_i && (speed_r != SPEED_MAX)) begin
      speed_nxt_s = speed_r + SPEED_WIDTH'(1);
      speed_chg_s = 1'b1;
    end else if (speed_dn_i && !speed_up_i && (speed_r != SPEED_WIDTH'(0))) begin
      speed_nxt_s = speed_r - SPEED_WIDTH'(1);
      speed_chg_s = 1'b1;
    end else begin
      speed_nxt_s = speed_r;
      speed_chg_s = 1'b0;
    end

    tick_s   = (state_r == ST_RUN) && (div_cnt_r == div_last_s);
    strobe_s = tick_s || (step_i && ((state_r == ST_IDLE) || (state_r == ST_PAUSE)));

    // Position advances on each strobe already presented to the datapath.
    pos_wrap_s = overflow_o && (pos_r == POS_LAST);
    if (pos_wrap_s) begin
      lap_nxt_s = lap_cnt_r + LAP_WIDTH'(1);
    end else begin
      lap_nxt_s = lap_cnt_r;
    end

    // stop_i takes priority over start_i wherever both are meaningful.
    case (state_r)
      ST_IDLE: begin
        if (stop_i) begin
          state_base_s = ST_IDLE;
        end else if (start_i) begin
          state_base_s = ST_RUN;
        end else begin
          state_base_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_base_s = ST_PAUSE;
        end else begin
          state_base_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop_i) begin
          state_base_s = ST_PAUSE;
        end else if (start_i) begin
          state_base_s = ST_RUN;
        end else begin
          state_base_s = ST_PAUSE;
        end
      end
`ifdef WC_LAP_LIMIT_EN
      ST_DONE: begin
        if (start_i) begin
          state_base_s = ST_RUN;
          restart_s    = 1'b1;
        end else begin
          state_base_s = ST_DONE;
        end
      end
`endif
      default: begin
        state_base_s = ST_IDLE;
      end
    endcase

`ifdef WC_LAP_LIMIT_EN
    // Reaching the lap limit overrides any other transition.
    if (pos_wrap_s && (lap_nxt_s == LAP_WIDTH'(LAP_LIMIT))) begin
      state_nxt_s = ST_DONE;
    end else begin
      state_nxt_s = state_base_s;
    end
`else
    state_nxt_s = state_base_s;
`endif
  end

  // State, divider, position, lap and registered output updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      div_cnt_r  <= '0;
      speed_r    <= '0;
      pos_r      <= '0;
      lap_cnt_r  <= '0;
      overflow_o <= 1'b0;
      running_o  <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      speed_r   <= speed_nxt_s;
      running_o <= (state_nxt_s == ST_RUN);
`ifdef WC_LAP_LIMIT_EN
      done_o     <= (state_nxt_s == ST_DONE);
      overflow_o <= strobe_s && (state_nxt_s != ST_DONE);
`else
      done_o     <= 1'b0;
      overflow_o <= strobe_s;
`endif

      // Divider: cleared in IDLE, on restart or speed change; counts in RUN;
      // holds in PAUSE so a resume continues the interrupted period.
      if ((state_r == ST_IDLE) || restart_s || speed_chg_s) begin
        div_cnt_r <= '0;
      end else if (state_r == ST_RUN) begin
        if (tick_s) begin
          div_cnt_r <= '0;
        end else begin
          div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
        end
      end else begin
        div_cnt_r <= div_cnt_r;
      end

      if (restart_s) begin
        pos_r     <= '0;
        lap_cnt_r <= '0;
      end else if (overflow_o) begin
        if (pos_wrap_s) begin
          pos_r <= '0;
        end else begin
          pos_r <= pos_r + POS_WIDTH'(1);
        end
        lap_cnt_r <= lap_nxt_s;
      end else begin
        pos_r     <= pos_r;
        lap_cnt_r <= lap_cnt_r;
      end
    end
  end

endmodule
